// File: rtl/lockstep_mem_voter.sv
// lockstep_mem_voter
// Sits between N_CORES redundant cores and one shared memory port. Each cycle
// with a request, it compares the per-core request bundles
// {req, we, be, addr, wdata}. It forwards the agreed bundle to memory in the
// same cycle and fans the grant/response back to every core. Disagreements
// are flagged, counted and attributed to cores. A disagreement that cannot
// be resolved halts the port until clear_i.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   core_*_i            per-core request bundles, core k in slice k
//   core_gnt_o          grant, identical on all bits
//   core_rvalid_o       response valid, identical on all bits
//   core_rdata_o        shared read data (mem_rdata_i)
//   mem_*_o / mem_*_i   single memory port
//   clear_i             clears fault state and leaves HALT
//   halt_o              port halted after an unresolvable mismatch
//   mismatch_o          combinational disagreement flag
//   fault_core_o        sticky per-core fault attribution
//   err_cnt_o           saturating count of disagreement cycles
//   proto_err_o         sticky: rvalid arrived with nothing outstanding
module lockstep_mem_voter #(
   parameter int N_CORES    = 3,
   parameter int VOTE_MODE  = 1,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = DATA_WIDTH / 8,
   parameter int MAX_OUT    = 2,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [N_CORES-1:0]            core_req_i,
   input  logic [N_CORES-1:0]            core_we_i,
   input  logic [N_CORES*BE_WIDTH-1:0]   core_be_i,
   input  logic [N_CORES*ADDR_WIDTH-1:0] core_addr_i,
   input  logic [N_CORES*DATA_WIDTH-1:0] core_wdata_i,
   output logic [N_CORES-1:0]            core_gnt_o,
   output logic [N_CORES-1:0]            core_rvalid_o,
   output logic [DATA_WIDTH-1:0]         core_rdata_o,
   output logic                          mem_req_o,
   output logic                          mem_we_o,
   output logic [BE_WIDTH-1:0]           mem_be_o,
   output logic [ADDR_WIDTH-1:0]         mem_addr_o,
   output logic [DATA_WIDTH-1:0]         mem_wdata_o,
   input  logic                          mem_gnt_i,
   input  logic                          mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
   input  logic                          clear_i,
   output logic                          halt_o,
   output logic                          mismatch_o,
   output logic [N_CORES-1:0]            fault_core_o,
   output logic [CNT_WIDTH-1:0]          err_cnt_o,
   output logic                          proto_err_o
);

   // Majority voting needs at least three voters; with two cores it
   // degenerates to strict compare against core 0.
   localparam bit MAJORITY = (VOTE_MODE == 1) && (N_CORES > 2);
   localparam int OUT_W    = $clog2(MAX_OUT + 1);
   localparam logic [OUT_W-1:0] OUT_FULL = OUT_W'(MAX_OUT);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t                           state, state_nxt;
   logic [N_CORES-1:0][N_CORES-1:0]  eq;
   logic                             found;
   int                               sel;
   logic [N_CORES-1:0]               fault_vec;
   logic                             fwd_req;
   logic                             fwd_we;
   logic [BE_WIDTH-1:0]              fwd_be;
   logic [ADDR_WIDTH-1:0]            fwd_addr;
   logic [DATA_WIDTH-1:0]            fwd_wdata;
   logic                             any_req;
   logic                             compare_en;
   logic                             disagree;
   logic                             unresolved;
   logic                             full;
   logic                             inc;
   logic                             dec;
   logic [OUT_W-1:0]                 out_cnt;
   logic [N_CORES-1:0]               fault_q;
   logic [CNT_WIDTH-1:0]             err_q;
   logic                             proto_q;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   // Pairwise bundle equality; write data only matters for writes.
   always_comb begin
      eq = '0;
      for (int i = 0; i < N_CORES; i++) begin
         for (int j = 0; j < N_CORES; j++) begin
            eq[i][j] = (core_req_i[i] == core_req_i[j]) &&
                       (core_we_i[i]  == core_we_i[j])  &&
                       (core_be_i[i*BE_WIDTH +: BE_WIDTH] ==
                        core_be_i[j*BE_WIDTH +: BE_WIDTH]) &&
                       (core_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] ==
                        core_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]) &&
                       (!core_we_i[i] ||
                        (core_wdata_i[i*DATA_WIDTH +: DATA_WIDTH] ==
                         core_wdata_i[j*DATA_WIDTH +: DATA_WIDTH]));
         end
      end
   end

   // Winner selection: lowest-index core agreeing with a strict majority.
   // In strict mode core 0 is the master and must agree with everyone.
   always_comb begin
      int cnt;
      cnt   = 0;
      found = 1'b0;
      sel   = 0;
      if (MAJORITY) begin
         for (int i = 0; i < N_CORES; i++) begin
            cnt = 0;
            for (int j = 0; j < N_CORES; j++) begin
               cnt = cnt + (eq[i][j] ? 1 : 0);
            end
            if (!found && (cnt > N_CORES / 2)) begin
               found = 1'b1;
               sel   = i;
            end
         end
      end else begin
         found = &eq[0];
      end
   end

   // Forward the selected bundle; without a winner sel stays 0, so fault
   // attribution falls back to "differs from core 0".
   always_comb begin
      fwd_req   = 1'b0;
      fwd_we    = 1'b0;
      fwd_be    = '0;
      fwd_addr  = '0;
      fwd_wdata = '0;
      fault_vec = '0;
      for (int k = 0; k < N_CORES; k++) begin
         if (k == sel) begin
            fwd_req   = core_req_i[k];
            fwd_we    = core_we_i[k];
            fwd_be    = core_be_i[k*BE_WIDTH +: BE_WIDTH];
            fwd_addr  = core_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            fwd_wdata = core_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            fault_vec = ~eq[k];
         end
      end
   end

   assign any_req    = |core_req_i;
   assign compare_en = any_req && (state == RUN);
   assign disagree   = !found || (fault_vec != '0);
   assign mismatch_o = compare_en && disagree;
   assign unresolved = compare_en && !found;
   // A response arriving in the same cycle does not unblock a full port.
   assign full       = (out_cnt == OUT_FULL);

   assign mem_req_o   = compare_en && found && fwd_req && !full;
   assign mem_we_o    = fwd_we;
   assign mem_be_o    = fwd_be;
   assign mem_addr_o  = fwd_addr;
   assign mem_wdata_o = fwd_wdata;

   assign core_gnt_o    = {N_CORES{mem_req_o & mem_gnt_i}};
   // Responses with nothing outstanding are stale and are dropped.
   assign core_rvalid_o = {N_CORES{mem_rvalid_i && (out_cnt != '0)}};
   assign core_rdata_o  = mem_rdata_i;

   assign inc = mem_req_o & mem_gnt_i;
   assign dec = mem_rvalid_i && (out_cnt != '0);

   // Outstanding-transaction counter and protocol error flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_cnt <= '0;
         proto_q <= 1'b0;
      end else begin
         case ({inc, dec})
            2'b10:   out_cnt <= out_cnt + OUT_W'(1);
            2'b01:   out_cnt <= out_cnt - OUT_W'(1);
            default: out_cnt <= out_cnt;
         endcase
         if (mem_rvalid_i && (out_cnt == '0)) begin
            proto_q <= 1'b1;
         end
      end
   end

   // Fault attribution and error counter; clear wins over a same-cycle mismatch
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fault_q <= '0;
         err_q   <= '0;
      end else if (clear_i) begin
         fault_q <= '0;
         err_q   <= '0;
      end else if (mismatch_o) begin
         fault_q <= fault_q | fault_vec;
         err_q   <= sat_inc(err_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (unresolved) state_nxt = HALT;
         HALT:    if (clear_i)    state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   assign halt_o       = (state == HALT);
   assign fault_core_o = fault_q;
   assign err_cnt_o    = err_q;
   assign proto_err_o  = proto_q;

endmodule
